// File: rtl/microsequencer_if.sv
// Sequencer handshake bundle: control-word/IR/flag inputs toward the sequencer,
// next address, current uPC and error pulses back.
interface microsequencer_if #(
    parameter int AW  = 5,
    parameter int OPW = 4
);
    logic [1:0]     nssel;
    logic [AW-1:0]  dbin;
    logic [OPW-1:0] opcode;
    logic [1:0]     amode;
    logic           zflag;
    logic           stall;
    logic [AW-1:0]  address;
    logic [AW-1:0]  upc;
    logic           stack_err;
    logic           illegal_op;

    modport master (
        output nssel, dbin, opcode, amode, zflag, stall,
        input  address, upc, stack_err, illegal_op
    );

    modport slave (
        input  nssel, dbin, opcode, amode, zflag, stall,
        output address, upc, stack_err, illegal_op
    );
endinterface

// File: rtl/microsequencer.sv
// Next-address generator for the control store: jump, conditional, opcode dispatch, call/return.
// Latency: address is combinational from inputs/uPC; upc and error pulses register on the next edge.
// Backpressure: stall holds address at upc and blocks all stack activity and flag pulses.
module microsequencer #(
    parameter int AW          = 5,
    parameter int OPW         = 4,
    parameter int STACK_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    microsequencer_if.slave bus
);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0] upc_q;
    logic [AW-1:0] stk_q [STACK_DEPTH];
    logic [CW-1:0] cnt_q;
    logic          stack_err_q;
    logic          illegal_q;

    logic [AW-1:0] addr_d;
    logic [AW-1:0] entry;
    logic          entry_ok;
    logic          mem_op;
    logic          push;
    logic          pop;
    logic          err_d;
    logic          ill_d;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] top_idx;

    assign push_idx = IW'(cnt_q);
    assign top_idx  = IW'(cnt_q - CW'(1));
    assign mem_op   = (int'(bus.opcode) >= 6) && (int'(bus.opcode) <= 9);

    always_comb begin
        entry    = '0;
        entry_ok = 1'b1;
        case (int'(bus.opcode))
            0:       entry = AW'(15);
            1:       entry = AW'(16);
            2:       entry = AW'(17);
            3:       entry = AW'(19);
            4:       entry = AW'(21);
            5:       entry = AW'(9);
            6:       entry = AW'(10);
            7:       entry = AW'(11);
            8:       entry = AW'(12);
            9:       entry = AW'(14);
            10:      entry = AW'(26);
            default: entry_ok = 1'b0;
        endcase
    end

    always_comb begin
        addr_d = upc_q;
        push   = 1'b0;
        pop    = 1'b0;
        err_d  = 1'b0;
        ill_d  = 1'b0;
        if (!bus.stall) begin
            case (bus.nssel)
                2'b00: addr_d = bus.dbin;
                2'b11: addr_d = bus.zflag ? bus.dbin : bus.dbin + AW'(1);
                2'b01: begin
                    if (!entry_ok) begin
                        addr_d = '0;
                        ill_d  = 1'b1;
                    end else if (mem_op && bus.amode == 2'd3) begin
                        addr_d = '0;
                        ill_d  = 1'b1;
                    end else if (mem_op && bus.amode != 2'd0) begin
                        // Mode routine runs first and returns to the opcode entry.
                        addr_d = (bus.amode == 2'd1) ? AW'(1) : AW'(5);
                        if (cnt_q == CW'(STACK_DEPTH)) err_d = 1'b1;
                        else                           push  = 1'b1;
                    end else begin
                        addr_d = entry;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        addr_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        addr_d = stk_q[top_idx];
                        pop    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            upc_q       <= '0;
            cnt_q       <= '0;
            stack_err_q <= 1'b0;
            illegal_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            upc_q       <= addr_d;
            stack_err_q <= err_d;
            illegal_q   <= ill_d;
            if (push) begin
                stk_q[push_idx] <= entry;
                cnt_q           <= cnt_q + CW'(1);
            end else if (pop) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign bus.address    = reset_n ? addr_d : '0;
    assign bus.upc        = upc_q;
    assign bus.stack_err  = stack_err_q;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_microsequencer.sv
module tb_microsequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    microsequencer_if bus ();

    microsequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] ns, input logic [4:0] db, input logic [3:0] op,
                         input logic [1:0] am, input logic z, input logic st);
        bus.nssel  = ns;
        bus.dbin   = db;
        bus.opcode = op;
        bus.amode  = am;
        bus.zflag  = z;
        bus.stall  = st;
    endtask

    task automatic test_reset;
        drive(2'b00, 5'd7, 4'h0, 2'd0, 1'b0, 1'b0);
        #2;
        checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL rst_address got=%0d exp=0", bus.address); end
        checks++; if (bus.upc !== 5'd0) begin errors++; $display("FAIL rst_upc got=%0d exp=0", bus.upc); end
        checks++; if (bus.stack_err !== 1'b0 || bus.illegal_op !== 1'b0) begin errors++; $display("FAIL rst_flags got=%b%b exp=00", bus.stack_err, bus.illegal_op); end
        tick;
        reset_n = 1'b1;
        drive(2'b00, 5'd9, 4'h0, 2'd0, 1'b0, 1'b0);
        tick;
        checks++; if (bus.upc !== 5'd9) begin errors++; $display("FAIL pre_rst_upc got=%0d exp=9", bus.upc); end
        drive(2'b00, 5'd17, 4'h0, 2'd0, 1'b0, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL async_rst_address got=%0d exp=0", bus.address); end
        checks++; if (bus.upc !== 5'd0) begin errors++; $display("FAIL async_rst_upc got=%0d exp=0", bus.upc); end
        tick;
        reset_n = 1'b1;
        drive(2'b00, 5'd23, 4'h0, 2'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd23) begin errors++; $display("FAIL jump23_address got=%0d exp=23", bus.address); end
        tick;
        checks++; if (bus.upc !== 5'd23) begin errors++; $display("FAIL jump23_upc got=%0d exp=23", bus.upc); end
    endtask

    task automatic test_cond;
        drive(2'b11, 5'd6, 4'h0, 2'd0, 1'b1, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd6) begin errors++; $display("FAIL cond_z1 got=%0d exp=6", bus.address); end
        bus.zflag = 1'b0;
        #1;
        checks++; if (bus.address !== 5'd7) begin errors++; $display("FAIL cond_z0 got=%0d exp=7", bus.address); end
        bus.dbin = 5'd31;
        #1;
        checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL cond_wrap got=%0d exp=0", bus.address); end
        tick;
        checks++; if (bus.upc !== 5'd0) begin errors++; $display("FAIL cond_wrap_upc got=%0d exp=0", bus.upc); end
    endtask

    task automatic test_call_return;
        drive(2'b01, 5'd3, 4'h6, 2'd1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd1) begin errors++; $display("FAIL call_address got=%0d exp=1", bus.address); end
        tick;
        checks++; if (bus.upc !== 5'd1 || bus.stack_err !== 1'b0) begin errors++; $display("FAIL call_state upc=%0d err=%b exp upc=1 err=0", bus.upc, bus.stack_err); end
        drive(2'b10, 5'd0, 4'h0, 2'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd10) begin errors++; $display("FAIL ret_address got=%0d exp=10", bus.address); end
        tick;
        checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL ret_err got=%b exp=0", bus.stack_err); end
    endtask

    task automatic test_empty_pop;
        drive(2'b10, 5'd4, 4'h0, 2'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL empty_pop_address got=%0d exp=0", bus.address); end
        tick;
        checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL empty_pop_err got=%b exp=1", bus.stack_err); end
        drive(2'b00, 5'd2, 4'h0, 2'd0, 1'b0, 1'b0);
        tick;
        checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL empty_pop_pulse got=%b exp=0", bus.stack_err); end
    endtask

    task automatic test_illegal;
        drive(2'b01, 5'd8, 4'hC, 2'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL opC_address got=%0d exp=0", bus.address); end
        tick;
        checks++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL opC_illegal got=%b exp=1", bus.illegal_op); end
        drive(2'b01, 5'd8, 4'h7, 2'd3, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL amode3_address got=%0d exp=0", bus.address); end
        tick;
        checks++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL amode3_illegal got=%b exp=1", bus.illegal_op); end
        drive(2'b01, 5'd0, 4'h3, 2'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd19) begin errors++; $display("FAIL op3_address got=%0d exp=19", bus.address); end
        tick;
        checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL op3_illegal got=%b exp=0", bus.illegal_op); end
        drive(2'b01, 5'd0, 4'h1, 2'd3, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd16) begin errors++; $display("FAIL op1_address got=%0d exp=16", bus.address); end
        bus.opcode = 4'h8; bus.amode = 2'd0;
        #1;
        checks++; if (bus.address !== 5'd12) begin errors++; $display("FAIL op8_am0_address got=%0d exp=12", bus.address); end
        bus.opcode = 4'hA;
        #1;
        checks++; if (bus.address !== 5'd26) begin errors++; $display("FAIL opA_address got=%0d exp=26", bus.address); end
        tick;
        checks++; if (bus.illegal_op !== 1'b0 || bus.stack_err !== 1'b0) begin errors++; $display("FAIL opA_flags got=%b%b exp=00", bus.illegal_op, bus.stack_err); end
        drive(2'b10, 5'd0, 4'h0, 2'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL illegal_nopush_address got=%0d exp=0", bus.address); end
        tick;
        checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL illegal_nopush_err got=%b exp=1", bus.stack_err); end
    endtask

    task automatic test_stall;
        drive(2'b00, 5'd4, 4'h0, 2'd0, 1'b0, 1'b0);
        tick;
        drive(2'b01, 5'd0, 4'h8, 2'd2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.address !== 5'd4) begin errors++; $display("FAIL stall_address cyc=%0d got=%0d exp=4", i, bus.address); end
            tick;
            checks++; if (bus.upc !== 5'd4 || bus.stack_err !== 1'b0 || bus.illegal_op !== 1'b0) begin errors++; $display("FAIL stall_hold cyc=%0d upc=%0d flags=%b%b exp upc=4 flags=00", i, bus.upc, bus.stack_err, bus.illegal_op); end
        end
        bus.stall = 1'b0;
        #1;
        checks++; if (bus.address !== 5'd5) begin errors++; $display("FAIL unstall_address got=%0d exp=5", bus.address); end
        tick;
        drive(2'b10, 5'd0, 4'h0, 2'd0, 1'b0, 1'b1);
        #1;
        checks++; if (bus.address !== 5'd5) begin errors++; $display("FAIL stall_ret_address got=%0d exp=5", bus.address); end
        tick;
        bus.stall = 1'b0;
        #1;
        checks++; if (bus.address !== 5'd12) begin errors++; $display("FAIL stall_ret_pop got=%0d exp=12", bus.address); end
        tick;
        #1;
        checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL stall_single_push got=%0d exp=0", bus.address); end
        tick;
        checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL stall_single_push_err got=%b exp=1", bus.stack_err); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp_pop [3];
        exp_pop[0] = 5'd10; exp_pop[1] = 5'd14; exp_pop[2] = 5'd0;
        drive(2'b01, 5'd0, 4'h9, 2'd1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd1) begin errors++; $display("FAIL push1_address got=%0d exp=1", bus.address); end
        tick;
        drive(2'b01, 5'd0, 4'h6, 2'd2, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd5) begin errors++; $display("FAIL push2_address got=%0d exp=5", bus.address); end
        tick;
        checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL push2_err got=%b exp=0", bus.stack_err); end
        drive(2'b01, 5'd0, 4'h7, 2'd1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd1) begin errors++; $display("FAIL overflow_address got=%0d exp=1", bus.address); end
        tick;
        checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL overflow_err got=%b exp=1", bus.stack_err); end
        drive(2'b10, 5'd0, 4'h0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.address !== exp_pop[i]) begin errors++; $display("FAIL lifo_pop%0d got=%0d exp=%0d", i, bus.address, exp_pop[i]); end
            tick;
        end
        checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL lifo_underflow_err got=%b exp=1", bus.stack_err); end
    endtask

    task automatic test_reset_stack;
        drive(2'b01, 5'd0, 4'h6, 2'd1, 1'b0, 1'b0);
        tick;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.address !== 5'd0 || bus.stack_err !== 1'b0) begin errors++; $display("FAIL midrst address=%0d err=%b exp 0/0", bus.address, bus.stack_err); end
        tick;
        reset_n = 1'b1;
        drive(2'b10, 5'd0, 4'h0, 2'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL midrst_pop got=%0d exp=0", bus.address); end
        tick;
        checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL midrst_pop_err got=%b exp=1", bus.stack_err); end
        drive(2'b00, 5'd0, 4'h0, 2'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.address !== 5'd0) begin errors++; $display("FAIL zero_word got=%0d exp=0", bus.address); end
        tick;
        checks++; if (bus.upc !== 5'd0 || bus.stack_err !== 1'b0) begin errors++; $display("FAIL zero_word_state upc=%0d err=%b exp 0/0", bus.upc, bus.stack_err); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_cond;
        test_call_return;
        test_empty_pop;
        test_illegal;
        test_stall;
        test_back_to_back;
        test_reset_stack;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
